brightled_multi: RTL

Parametrised N-channel successor to the single-LED brightness controller. Three buttons drive it: plus, minus and channel-select. Each button is synchronised and debounced. Plus and minus step the brightness level of the selected channel, with saturation at both ends. Each channel drives one LED through a PWM generator; all channels share one prescaled period counter.

---
 rtl/brightled_multi.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/brightled_multi.sv
// N-channel LED brightness controller: three debounced buttons step the selected channel's level, shared-counter PWM per channel.
// Optional auto-repeat on plus/minus is enabled by defining BRIGHTLED_MULTI_REPEAT_EN.
module brightled_multi #(
  parameter int CHANNELS        = 4,
  parameter int LEVEL_W         = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PRESCALE        = 1,
  parameter int RESET_LEVEL     = 0,
  parameter int REPEAT_DELAY    = 256,
  parameter int REPEAT_PERIOD   = 64
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             button_plus,
  input  logic                                             button_minus,
  input  logic                                             button_sel,
  output logic [CHANNELS-1:0]                              led,
  output logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] sel_ch,
  output logic [LEVEL_W-1:0]                               sel_level
);

  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [LEVEL_W-1:0] MAX_LEVEL = {LEVEL_W{1'b1}};

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  localparam int BTN_PLUS  = 0;
  localparam int BTN_MINUS = 1;
  localparam int BTN_SEL   = 2;

`ifdef BRIGHTLED_MULTI_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  logic [2:0] raw;
  logic [2:0] meta_q;
  logic [2:0] sync_q;
  logic [2:0] btn_pulse;

  assign raw = {button_sel, button_minus, button_plus};

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
    end
  end

  for (genvar b = 0; b < 3; b++) begin : g_db
    logic [1:0]       state_q;
    logic [DB_W-1:0]  cnt_q;
    logic [RPT_W-1:0] rpt_q;
    logic             s;
    logic             db_done;
    logic             press_fire;
    logic             rpt_fire;
    logic             pulse;

    assign s = sync_q[b];
    // The sample that left the previous state counts as the first stable one.
    assign db_done    = (int'(cnt_q) + 2 >= DEBOUNCE_CYCLES);
    assign press_fire = s && ((state_q == ST_IDLE && DEBOUNCE_CYCLES == 1) ||
                              (state_q == ST_PRESS_WAIT && db_done));
    assign rpt_fire   = REPEAT_EN && (b != BTN_SEL) && s && (state_q == ST_HELD) && (rpt_q == '0);
    assign pulse      = press_fire || rpt_fire;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        rpt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (s) begin
              cnt_q   <= '0;
              rpt_q   <= RPT_W'(REPEAT_DELAY - 1);
              state_q <= (DEBOUNCE_CYCLES == 1) ? ST_HELD : ST_PRESS_WAIT;
            end
          end
          ST_PRESS_WAIT: begin
            if (!s) begin
              state_q <= ST_IDLE;
            end else if (db_done) begin
              state_q <= ST_HELD;
              rpt_q   <= RPT_W'(REPEAT_DELAY - 1);
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_HELD: begin
            if (!s) begin
              cnt_q   <= '0;
              state_q <= (DEBOUNCE_CYCLES == 1) ? ST_IDLE : ST_RELEASE_WAIT;
            end else if (rpt_q == '0) begin
              rpt_q <= RPT_W'(REPEAT_PERIOD - 1);
            end else begin
              rpt_q <= rpt_q - 1'b1;
            end
          end
          ST_RELEASE_WAIT: begin
            // Repeat timer is frozen here so a bounce back to HELD resumes the cadence.
            if (s) begin
              state_q <= ST_HELD;
            end else if (db_done) begin
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign btn_pulse = {g_db[2].pulse, g_db[1].pulse, g_db[0].pulse};

  logic [LEVEL_W-1:0] level_q [CHANNELS];
  logic [SEL_W-1:0]   sel_q;
  logic               plus_p;
  logic               minus_p;

  assign plus_p  = btn_pulse[BTN_PLUS];
  assign minus_p = btn_pulse[BTN_MINUS];

  // NOTE: the level array is tiny and must start at RESET_LEVEL, so it is reset like ordinary flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) level_q[i] <= LEVEL_W'(RESET_LEVEL);
      sel_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (SEL_W'(i) == sel_q) begin
          if (plus_p && !minus_p && level_q[i] != MAX_LEVEL) begin
            level_q[i] <= level_q[i] + 1'b1;
          end else if (minus_p && !plus_p && level_q[i] != '0) begin
            level_q[i] <= level_q[i] - 1'b1;
          end
        end
      end
      if (btn_pulse[BTN_SEL]) begin
        sel_q <= (sel_q == SEL_W'(CHANNELS - 1)) ? '0 : sel_q + 1'b1;
      end
    end
  end

  logic [PS_W-1:0]    ps_q;
  logic [LEVEL_W-1:0] pwm_q;
  logic [CHANNELS-1:0] led_q;

  // Period counter spans 0..MAX_LEVEL-1, so MAX_LEVEL compares as always on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q  <= '0;
      pwm_q <= '0;
      led_q <= '0;
    end else begin
      if (ps_q == PS_W'(PRESCALE - 1)) begin
        ps_q  <= '0;
        pwm_q <= (pwm_q == MAX_LEVEL - 1'b1) ? '0 : pwm_q + 1'b1;
      end else begin
        ps_q <= ps_q + 1'b1;
      end
      for (int i = 0; i < CHANNELS; i++) led_q[i] <= (pwm_q < level_q[i]);
    end
  end

  assign led       = led_q;
  assign sel_ch    = sel_q;
  assign sel_level = level_q[sel_q];

endmodule
